// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  function automatic logic req_active(input mem_req_t r);
    return |(r.rmask | r.wmask);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Split fetch/data ports plus the shared downstream memory port.
interface mem_port_arbiter_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  // arbiter view
  modport slave (
    input  imem_addr, imem_rmask,
    output imem_rdata, imem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    output mem_addr, mem_rmask, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp
  );

  // cpu stages + memory view
  modport master (
    output imem_addr, imem_rmask,
    input  imem_rdata, imem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_port_arbiter_mem_req_buf.sv
// One-entry holding slot for a request that lost arbitration or arrived while busy.
module mem_req_buf
  import mem_port_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     clear,
  input  mem_req_t load_req,
  output logic     valid,
  output mem_req_t req
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      req   <= load_req;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between fetch and data ports:
// one pending slot per side, one outstanding request, responses routed to the owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit DMEM_FIRST = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave port,
  output logic [CNT_W-1:0] imem_wait_cnt,
  output logic [CNT_W-1:0] dmem_wait_cnt
);

  arb_state_t state, state_nxt;
  mem_req_t   i_new, d_new, i_pend, d_pend, i_cand_req, d_cand_req, issue;
  logic       i_pend_v, d_pend_v;
  logic       i_in, d_in, i_busy, d_busy, i_acc, d_acc;
  logic       i_cand, d_cand, arb_en, resp_ok, gnt_i, gnt_d;
  logic       last_d;
  logic       rst_q;
  logic       imem_resp_c, dmem_resp_c;

  assign i_new = '{addr: port.imem_addr, rmask: port.imem_rmask, wmask: 4'h0, wdata: 32'h0};
  assign d_new = '{addr: port.dmem_addr, rmask: port.dmem_rmask,
                   wmask: port.dmem_wmask, wdata: port.dmem_wdata};
  assign i_in  = req_active(i_new);
  assign d_in  = req_active(d_new);

  // A response only counts while something is actually in flight.
  assign resp_ok = port.mem_resp && !rst && (state != IDLE);

  // A side may re-request in the same cycle its response returns.
  assign i_busy = i_pend_v || (state == BUSY_I && !resp_ok);
  assign d_busy = d_pend_v || (state == BUSY_D && !resp_ok);
  assign i_acc  = i_in && !i_busy && !rst;
  assign d_acc  = d_in && !d_busy && !rst;

  assign i_cand     = i_pend_v || i_acc;
  assign d_cand     = d_pend_v || d_acc;
  assign i_cand_req = i_pend_v ? i_pend : i_new;
  assign d_cand_req = d_pend_v ? d_pend : d_new;

  assign arb_en = !rst && (state == IDLE || port.mem_resp);
  assign gnt_d  = arb_en && d_cand && (!i_cand || DMEM_FIRST || !last_d);
  assign gnt_i  = arb_en && i_cand && !gnt_d;

  mem_req_buf u_ibuf (
    .clk      (clk),
    .rst      (rst),
    .load     (i_acc && !gnt_i),
    .clear    (gnt_i),
    .load_req (i_new),
    .valid    (i_pend_v),
    .req      (i_pend)
  );

  mem_req_buf u_dbuf (
    .clk      (clk),
    .rst      (rst),
    .load     (d_acc && !gnt_d),
    .clear    (gnt_d),
    .load_req (d_new),
    .valid    (d_pend_v),
    .req      (d_pend)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue       = '0;
    imem_resp_c = 1'b0;
    dmem_resp_c = 1'b0;
    if (gnt_d)      issue = d_cand_req;
    else if (gnt_i) issue = i_cand_req;
    if (arb_en) begin
      if (gnt_d)      state_nxt = BUSY_D;
      else if (gnt_i) state_nxt = BUSY_I;
      else            state_nxt = IDLE;
    end
    if (resp_ok && state == BUSY_I) imem_resp_c = 1'b1;
    if (resp_ok && state == BUSY_D) dmem_resp_c = 1'b1;
  end

  assign port.mem_addr   = issue.addr;
  assign port.mem_rmask  = issue.rmask;
  assign port.mem_wmask  = issue.wmask;
  assign port.mem_wdata  = issue.wdata;
  assign port.imem_resp  = imem_resp_c;
  assign port.dmem_resp  = dmem_resp_c;
  assign port.imem_rdata = imem_resp_c ? port.mem_rdata : 32'h0;
  assign port.dmem_rdata = dmem_resp_c ? port.mem_rdata : 32'h0;

  // Round-robin history: set when dmem took the latest grant.
  always_ff @(posedge clk) begin
    if (rst)                last_d <= 1'b0;
    else if (gnt_i || gnt_d) last_d <= gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_wait_cnt <= '0;
      dmem_wait_cnt <= '0;
    end else begin
      if (i_pend_v && !gnt_i && imem_wait_cnt != '1) imem_wait_cnt <= imem_wait_cnt + 1'b1;
      if (d_pend_v && !gnt_d && dmem_wait_cnt != '1) dmem_wait_cnt <= dmem_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) rst_q <= rst;

  a_imem_proto: assert property (@(posedge clk) disable iff (rst) !(i_in && i_busy));
  a_dmem_proto: assert property (@(posedge clk) disable iff (rst) !(d_in && d_busy));
  // A stray response from before reset may land in the first cycle out of reset.
  a_idle_resp:  assert property (@(posedge clk) disable iff (rst)
                                 !(port.mem_resp && state == IDLE && !rst_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter against a transaction-level model
// (per-side waiting requests, one in-flight request, memory with chosen latency).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   sel = 1'b0;   // 0: fixed-priority DUT (CNT_W=4), 1: round-robin DUT
  always #5 clk = ~clk;

  logic [31:0] i_addr = '0, d_addr = '0, d_wd = '0, m_rdata = '0;
  logic [3:0]  i_rm = '0, d_rm = '0, d_wm = '0;
  logic        m_resp = 1'b0;
  logic [3:0]  icnt_a, dcnt_a;
  logic [31:0] icnt_b, dcnt_b;

  mem_port_arbiter_if ifa ();
  mem_port_arbiter_if ifb ();

  assign ifa.imem_addr  = i_addr;  assign ifb.imem_addr  = i_addr;
  assign ifa.dmem_addr  = d_addr;  assign ifb.dmem_addr  = d_addr;
  assign ifa.dmem_wdata = d_wd;    assign ifb.dmem_wdata = d_wd;
  assign ifa.mem_rdata  = m_rdata; assign ifb.mem_rdata  = m_rdata;
  assign ifa.imem_rmask = sel ? 4'h0 : i_rm;  assign ifb.imem_rmask = sel ? i_rm : 4'h0;
  assign ifa.dmem_rmask = sel ? 4'h0 : d_rm;  assign ifb.dmem_rmask = sel ? d_rm : 4'h0;
  assign ifa.dmem_wmask = sel ? 4'h0 : d_wm;  assign ifb.dmem_wmask = sel ? d_wm : 4'h0;
  assign ifa.mem_resp   = sel ? 1'b0 : m_resp; assign ifb.mem_resp  = sel ? m_resp : 1'b0;

  mem_port_arbiter #(.DMEM_FIRST(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .port(ifa.slave), .imem_wait_cnt(icnt_a), .dmem_wait_cnt(dcnt_a));
  mem_port_arbiter #(.DMEM_FIRST(1'b0), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .port(ifb.slave), .imem_wait_cnt(icnt_b), .dmem_wait_cnt(dcnt_b));

  wire [31:0] o_maddr = sel ? ifb.mem_addr   : ifa.mem_addr;
  wire [3:0]  o_mrm   = sel ? ifb.mem_rmask  : ifa.mem_rmask;
  wire [3:0]  o_mwm   = sel ? ifb.mem_wmask  : ifa.mem_wmask;
  wire [31:0] o_mwd   = sel ? ifb.mem_wdata  : ifa.mem_wdata;
  wire        o_ir    = sel ? ifb.imem_resp  : ifa.imem_resp;
  wire        o_dr    = sel ? ifb.dmem_resp  : ifa.dmem_resp;
  wire [31:0] o_ird   = sel ? ifb.imem_rdata : ifa.imem_rdata;
  wire [31:0] o_drd   = sel ? ifb.dmem_rdata : ifa.dmem_rdata;
  wire [31:0] o_icnt  = sel ? icnt_b : {28'h0, icnt_a};
  wire [31:0] o_dcnt  = sel ? dcnt_b : {28'h0, dcnt_a};

  int checks = 0, failures = 0;

  // Reference model: side 0 = imem, side 1 = dmem.
  bit          wq_v[2];
  mem_req_t    wq[2];
  bit          fl_v;
  int          fl_side, fl_age, fl_lat, last;
  logic [31:0] cnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wq_v = '{1'b0, 1'b0};
    fl_v = 1'b0; fl_side = 0; fl_age = 0; fl_lat = 0; last = 0;
    cnt = '{32'h0, 32'h0};
  endtask

  // One clock of stimulus and checking. lat is the memory latency given to a
  // request issued in this cycle; late forces a stray mem_resp.
  task automatic cyc(input bit pi, input bit pd, input logic [31:0] ia, input logic [31:0] da,
                     input logic [3:0] drm, input logic [3:0] dwm, input logic [31:0] dwd,
                     input int lat, input bit late);
    bit          pe[2];
    mem_req_t    nr[2];
    mem_req_t    er;
    int          win;
    bit          free, ic, dc, ir_exp, dr_exp;
    logic [31:0] cmax;
    @(posedge clk); #1;
    rst = 1'b0;
    if (fl_v) fl_age++;
    m_resp  = late || (fl_v && fl_age >= fl_lat);
    m_rdata = $urandom;
    pe[0] = pi && !wq_v[0] && !(fl_v && fl_side == 0 && !m_resp);
    pe[1] = pd && (|(drm | dwm)) && !wq_v[1] && !(fl_v && fl_side == 1 && !m_resp);
    nr[0] = '{addr: ia, rmask: 4'hf, wmask: 4'h0, wdata: 32'h0};
    nr[1] = '{addr: da, rmask: drm, wmask: dwm, wdata: dwd};
    i_addr = ia; i_rm = pe[0] ? 4'hf : 4'h0;
    d_addr = da; d_rm = pe[1] ? drm : 4'h0; d_wm = pe[1] ? dwm : 4'h0; d_wd = dwd;
    @(negedge clk);
    ir_exp = m_resp && fl_v && fl_side == 0;
    dr_exp = m_resp && fl_v && fl_side == 1;
    chk("imem_resp", 32'(o_ir), 32'(ir_exp));
    chk("dmem_resp", 32'(o_dr), 32'(dr_exp));
    if (ir_exp) chk("imem_rdata", o_ird, m_rdata);
    if (dr_exp) chk("dmem_rdata", o_drd, m_rdata);
    free = !fl_v || m_resp;
    ic = wq_v[0] || pe[0];
    dc = wq_v[1] || pe[1];
    win = -1;
    if (free) begin
      if (ic && dc) win = (!sel) ? 1 : ((last == 1) ? 0 : 1);
      else if (dc)  win = 1;
      else if (ic)  win = 0;
    end
    er = '0;
    if (win >= 0) er = wq_v[win] ? wq[win] : nr[win];
    chk("mem_rmask", 32'(o_mrm), 32'(er.rmask));
    chk("mem_wmask", 32'(o_mwm), 32'(er.wmask));
    if (win >= 0) chk("mem_addr", o_maddr, er.addr);
    if (er.wmask != 4'h0) chk("mem_wdata", o_mwd, er.wdata);
    chk("imem_wait_cnt", o_icnt, cnt[0]);
    chk("dmem_wait_cnt", o_dcnt, cnt[1]);
    // advance the model by one cycle
    cmax = sel ? 32'hffff_ffff : 32'h0000_000f;
    if (fl_v && m_resp) fl_v = 1'b0;
    for (int s = 0; s < 2; s++)
      if (wq_v[s] && win != s && cnt[s] != cmax) cnt[s] = cnt[s] + 32'd1;
    if (win >= 0) begin
      fl_v = 1'b1; fl_side = win; fl_age = 0; fl_lat = lat; last = win;
      wq_v[win] = 1'b0;
    end
    for (int s = 0; s < 2; s++)
      if (pe[s] && win != s) begin wq_v[s] = 1'b1; wq[s] = nr[s]; end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 1, 1'b0);
  endtask

  task automatic do_reset(input bit s);
    @(posedge clk); #1;
    rst = 1'b1; sel = s; m_resp = 1'b0;
    i_rm = '0; d_rm = '0; d_wm = '0;
    @(negedge clk);
    chk("rst_mem_rmask", 32'(o_mrm), 32'h0);
    chk("rst_mem_wmask", 32'(o_mwm), 32'h0);
    chk("rst_resp", 32'({o_ir, o_dr}), 32'h0);
    model_reset();
  endtask

  localparam logic [31:0] IA = 32'h1eceb000;
  localparam logic [31:0] DA = 32'h8000_0040;

  initial begin
    model_reset();
    @(posedge clk);
    do_reset(1'b0);

    // solo fetch, latency 3
    cyc(1'b1, 1'b0, IA, DA, 4'h0, 4'h0, 32'h0, 3, 1'b0);
    chk("solo_issue_rmask", 32'(o_mrm), 32'hf);
    chk("solo_issue_addr", o_maddr, IA);
    idle(2);
    idle(1);
    chk("solo_iresp", 32'(o_ir), 32'h1);
    chk("solo_no_dresp", 32'(o_dr), 32'h0);
    chk("solo_rdata", o_ird, m_rdata);

    // collision under fixed priority: dmem first, imem issued in the dmem response cycle
    cyc(1'b1, 1'b1, IA + 32'h4, DA, 4'hf, 4'h0, 32'h0, 3, 1'b0);
    chk("coll_first_d", o_maddr, DA);
    idle(2);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 2, 1'b0);
    chk("coll_dresp", 32'(o_dr), 32'h1);
    chk("coll_then_i", o_maddr, IA + 32'h4);
    idle(1);
    // imem slot valid in the two cycles strictly between issue of dmem and its response
    chk("coll_wait_cnt", o_icnt, 32'd2);
    idle(4);

    // store while fetch in flight
    cyc(1'b1, 1'b0, IA + 32'h8, DA, 4'h0, 4'h0, 32'h0, 3, 1'b0);
    cyc(1'b0, 1'b1, 32'h0, DA + 32'h8, 4'h0, 4'b0011, 32'hcafe_f00d, 2, 1'b0);
    chk("store_held", 32'(o_mwm), 32'h0);
    idle(1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 2, 1'b0);
    chk("store_issue_wmask", 32'(o_mwm), 32'h3);
    chk("store_issue_wdata", o_mwd, 32'hcafe_f00d);
    idle(2);
    chk("store_dresp", 32'(o_dr), 32'h1);
    idle(1);
    chk("store_dresp_once", 32'(o_dr), 32'h0);

    // back-to-back fetch: re-request in the response cycle, no bubble
    cyc(1'b1, 1'b0, IA + 32'h10, DA, 4'h0, 4'h0, 32'h0, 2, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, IA + 32'h14, DA, 4'h0, 4'h0, 32'h0, 2, 1'b0);
    chk("b2b_iresp", 32'(o_ir), 32'h1);
    chk("b2b_reissue", o_maddr, IA + 32'h14);
    chk("b2b_rmask", 32'(o_mrm), 32'hf);
    idle(3);

    // wait counter saturates at all-ones (4-bit counter here) and holds
    cyc(1'b1, 1'b1, IA, DA, 4'h1, 4'h0, 32'h0, 20, 1'b0);
    idle(24);
    chk("sat_icnt", o_icnt, 32'hf);

    // reset while BUSY_D with imem pending, stray response right after
    cyc(1'b1, 1'b1, IA, DA, 4'hf, 4'h0, 32'h0, 10, 1'b0);
    idle(2);
    do_reset(1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 1, 1'b1);
    chk("rst_late_iresp", 32'(o_ir), 32'h0);
    chk("rst_late_dresp", 32'(o_dr), 32'h0);
    chk("rst_icnt", o_icnt, 32'h0);
    chk("rst_dcnt", o_dcnt, 32'h0);
    cyc(1'b0, 1'b1, 32'h0, DA, 4'h3, 4'h0, 32'h0, 1, 1'b0);
    idle(1);
    chk("rst_no_stale_i", 32'(o_mrm), 32'h0);
    idle(2);

    // random traffic, fixed priority
    for (int k = 0; k < 300; k++) begin
      bit st;
      st = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom, $urandom,
          st ? 4'h0 : 4'($urandom_range(1, 15)), st ? 4'($urandom_range(1, 15)) : 4'h0,
          $urandom, int'($urandom_range(1, 4)), 1'b0);
    end
    idle(12);

    // round-robin: repeated ties alternate D, I, D, I
    do_reset(1'b1);
    cyc(1'b1, 1'b1, IA, DA, 4'hf, 4'h0, 32'h0, 1, 1'b0);
    chk("rr_grant0_d", o_maddr, DA);
    cyc(1'b0, 1'b1, IA, DA, 4'hf, 4'h0, 32'h0, 1, 1'b0);
    chk("rr_grant1_i", o_maddr, IA);
    cyc(1'b1, 1'b0, IA, DA, 4'hf, 4'h0, 32'h0, 1, 1'b0);
    chk("rr_grant2_d", o_maddr, DA);
    cyc(1'b0, 1'b1, IA, DA, 4'hf, 4'h0, 32'h0, 1, 1'b0);
    chk("rr_grant3_i", o_maddr, IA);
    idle(4);

    // random traffic, round-robin
    for (int k = 0; k < 300; k++) begin
      bit st;
      st = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, $urandom, $urandom,
          st ? 4'h0 : 4'($urandom_range(1, 15)), st ? 4'($urandom_range(1, 15)) : 4'h0,
          $urandom, int'($urandom_range(1, 3)), 1'b0);
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
